// File: rtl/fc_update_dllp_gen.sv
// Receive-side UpdateFC DLLP generator: watches per-buffer credit_limit words and
// emits one DLLP per buffer on change, link-up or refresh. Optional FC_UPDATE_STATS_EN adds a DLLP counter.
module fc_update_dllp_gen #(
    parameter int INFO_SIGNALS  = 10,
    parameter int NUM_BUF       = 3,
    parameter int UPDATE_PERIOD = 64,
    parameter int DLLP_W        = 32,
    localparam int IDX_W        = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 link_up,
    input  logic [NUM_BUF*(INFO_SIGNALS+3)-1:0]  credit_limit_in,
    output logic                                 dllp_valid,
    input  logic                                 dllp_ready,
    output logic [DLLP_W-1:0]                    dllp_data,
    output logic [IDX_W-1:0]                     dllp_buf_idx,
    output logic [15:0]                          dllp_count
);

    localparam int CW = INFO_SIGNALS + 3;
    localparam int TW = $clog2(UPDATE_PERIOD);

    // dllp_valid/dllp_ready: a word transfers on any edge where both are high; once
    // raised, valid and the word stay stable until that transfer (or rst / link down).
    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [TW-1:0]      timer;
    logic [CW-1:0]      last_sent [NUM_BUF];
    logic [CW-1:0]      cur_word  [NUM_BUF];
    logic [CW-1:0]      snapshot;
    logic [NUM_BUF-1:0] pending;
    logic [NUM_BUF-1:0] pending_nxt;
    logic               link_up_q;
    logic               timer_expire;
    logic               link_rise;
    logic               handshake;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

    function automatic logic [DLLP_W-1:0] fmt_dllp(input logic [CW-1:0] w);
        logic [DLLP_W-1:0] d;
        d = '0;
        d[DLLP_W-1 -: 8]        = {5'b10000, w[CW-1 -: 3]};
        d[INFO_SIGNALS-1:0]     = w[INFO_SIGNALS-1:0];
        return d;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_BUF; i++) begin
            cur_word[i] = credit_limit_in[i*CW +: CW];
        end
    end

    assign timer_expire = link_up && (timer == TW'(UPDATE_PERIOD - 1));
    assign link_rise    = link_up && !link_up_q;
    assign handshake    = dllp_valid && dllp_ready;

    // Round-robin: first pending buffer at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_BUF);
            if (!pick_found && pending[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The buffer being acknowledged keeps its request only if something new arrived
    // since its snapshot was taken, so no change or refresh is ever lost.
    always_comb begin
        pending_nxt = pending;
        if (!link_up) begin
            pending_nxt = '0;
        end else begin
            for (int i = 0; i < NUM_BUF; i++) begin
                if ((cur_word[i] != last_sent[i]) || timer_expire || link_rise) begin
                    pending_nxt[i] = 1'b1;
                end
            end
            if (handshake) begin
                pending_nxt[dllp_buf_idx] = (cur_word[dllp_buf_idx] != snapshot) ||
                                            timer_expire || link_rise;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            timer        <= '0;
            link_up_q    <= 1'b0;
            pending      <= '0;
            snapshot     <= '0;
            dllp_valid   <= 1'b0;
            dllp_data    <= '0;
            dllp_buf_idx <= '0;
            for (int i = 0; i < NUM_BUF; i++) begin
                last_sent[i] <= '0;
            end
        end else begin
            link_up_q <= link_up;
            pending   <= pending_nxt;

            if (!link_up || timer_expire) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if (handshake) begin
                last_sent[dllp_buf_idx] <= snapshot;
                rr_ptr <= (dllp_buf_idx == IDX_W'(NUM_BUF - 1)) ? '0 : dllp_buf_idx + IDX_W'(1);
            end

            case (state)
                IDLE: begin
                    if (link_up && pick_found) begin
                        snapshot     <= cur_word[pick_idx];
                        dllp_buf_idx <= pick_idx;
                        dllp_data    <= fmt_dllp(cur_word[pick_idx]);
                        dllp_valid   <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (!link_up || dllp_ready) begin
                        dllp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    dllp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef FC_UPDATE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dllp_count <= '0;
        end else if (handshake && (dllp_count != 16'hFFFF)) begin
            dllp_count <= dllp_count + 16'd1;
        end
    end
`else
    assign dllp_count = '0;
`endif

endmodule
